// File: rtl/ps2_key_mmio.sv
// PS/2 keyboard receiver that keeps the currently held scan code in a
// memory-mapped word. Frames are deserialized from the raw PS/2 lines. E0
// and F0 prefixes are decoded. Every change of the held key raises a
// single-word write request to the data memory arbiter.
module ps2_key_mmio #(
  parameter int          FILTER_LEN  = 4,
  parameter int          TIMEOUT_CYC = 50000,
  parameter logic [31:0] KEY_ADDR    = 32'd10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        wr_ack,
  output logic        wr_req,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [7:0]  key_code,
  output logic        key_ext,
  output logic        key_held,
  output logic        frame_err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  // Synchronizer and filter state. Both lines idle high, so they reset high.
  // A low reset value would fake a falling edge when reset is released.
  logic          clk_s1, clk_s2;
  logic          dat_s1, dat_s2;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          strobe;

  // Receiver state
  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          parity_ok;
  logic [TW-1:0] tmo_cnt;
  logic          byte_valid;

  // Decoder state
  logic          ext_pend, brk_pend;
  logic [7:0]    next_code;
  logic          next_ext;
  logic          next_ext_pend, next_brk_pend;
  logic          code_change;

  // Bring both raw PS/2 lines into the clk domain through two flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Change the filtered clock level only after FILTER_LEN equal samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_LAST) begin
      filt_clk <= clk_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  // The strobe fires in the cycle where the filtered clock is about to fall.
  // The data bit is sampled in that same cycle.
  assign strobe = filt_clk & ~clk_s2 & (filt_cnt == FILT_LAST);

  // A byte is complete when a good stop bit arrives after a good parity bit.
  assign byte_valid = strobe && (state == STOP) && dat_s2 && parity_ok;

  // Frame receiver FSM. One bit is taken per strobe.
  // The FSM also watches the time between strobes while inside a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      parity_ok <= 1'b0;
      tmo_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (strobe) begin
        tmo_cnt <= '0;
        case (state)
          IDLE: begin
            if (!dat_s2) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          DATA: begin
            shift_reg <= {dat_s2, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            parity_ok <= ^{dat_s2, shift_reg};
            state     <= STOP;
          end
          STOP: begin
            if (!(dat_s2 && parity_ok)) begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (tmo_cnt == TMO_LAST) begin
          state     <= IDLE;
          frame_err <= 1'b1;
          tmo_cnt   <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  // Work out the next key state from a received byte and the prefix flags.
  always_comb begin
    next_code     = key_code;
    next_ext      = key_ext;
    next_ext_pend = ext_pend;
    next_brk_pend = brk_pend;
    if (byte_valid) begin
      if (shift_reg == 8'hE0) begin
        next_ext_pend = 1'b1;
      end else if (shift_reg == 8'hF0) begin
        next_brk_pend = 1'b1;
      end else if (!brk_pend) begin
        // A repeat of the held key is ignored so that typematic does not
        // flood the memory with identical writes.
        if (shift_reg != key_code) begin
          next_code = shift_reg;
          next_ext  = ext_pend;
        end
        next_ext_pend = 1'b0;
        next_brk_pend = 1'b0;
      end else begin
        if (shift_reg == key_code) begin
          next_code = 8'h00;
          next_ext  = 1'b0;
        end
        next_ext_pend = 1'b0;
        next_brk_pend = 1'b0;
      end
    end
  end

  assign code_change = (next_code != key_code);

  // Register the key state. Each change raises or refreshes the write
  // request. An ack retires the request only when no new change arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_code <= '0;
      key_ext  <= 1'b0;
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
      wr_req   <= 1'b0;
      wr_data  <= '0;
    end else begin
      key_code <= next_code;
      key_ext  <= next_ext;
      ext_pend <= next_ext_pend;
      brk_pend <= next_brk_pend;
      if (code_change) begin
        wr_req  <= 1'b1;
        wr_data <= {24'h0, next_code};
      end else if (wr_ack) begin
        wr_req <= 1'b0;
      end
    end
  end

  assign wr_addr  = KEY_ADDR;
  assign key_held = |key_code;

endmodule

// File: doc/ps2_key_mmio.md
# ps2_key_mmio

PS/2 keyboard receiver and key-state writer that feeds the Gambling_Tec data memory. It deserializes PS/2 frames, tracks make, break (F0) and extended (E0) prefixes, and holds the scan code of the currently pressed key. Whenever that state changes it requests a word write of the held code into the memory-mapped key slot (word address 10). The CPU polls that slot: it reads 0x75 while UP is held and 0 after release.

## Interface

Parameters:
- FILTER_LEN, 4: cycles the synchronized ps2_clk must stay stable before an edge is accepted.
- TIMEOUT_CYC, 50000: idle cycles allowed between falling edges inside a frame before the frame is aborted.
- KEY_ADDR, 32'd10: RAM address written with the key word.

Ports:
- clk, in, 1: system clock; the only clock.
- rst, in, 1: reset, asynchronous and active-low.
- ps2_clk, in, 1: raw PS/2 clock, asynchronous to clk.
- ps2_data, in, 1: raw PS/2 data, asynchronous to clk.
- wr_ack, in, 1: memory arbiter accepted the pending write this cycle.
- wr_req, out, 1: write pending.
- wr_addr, out, 32: always KEY_ADDR.
- wr_data, out, 32: {24'h0, key_code} at the time of the last change.
- key_code, out, 8: held scan code; 0 when no key is held.
- key_ext, out, 1: held key was preceded by E0.
- key_held, out, 1: key_code != 0.
- frame_err, out, 1: one-cycle pulse on parity error, bad start/stop bit, or timeout.

## Operation

Input conditioning:
- ps2_clk and ps2_data each pass through a 2-FF synchronizer.
- ps2_clk is then glitch-filtered: the filtered level changes only after FILTER_LEN consecutive equal samples.
- A falling edge of the filtered clock is the sample strobe.

Receiver FSM (IDLE, DATA, PARITY, STOP), one ps2_data sample per strobe:
- IDLE: data=0 → DATA, bit count=0. data=1 is treated as a bad start bit: pulse frame_err, stay in IDLE.
- DATA: shift LSB first; after 8 bits → PARITY.
- PARITY: check that the 8 data bits plus the parity bit have odd parity → STOP.
- STOP: data=1 with parity OK → byte_valid for one cycle. Any other case → frame_err. Both paths return to IDLE.
- Timeout: any state other than IDLE with TIMEOUT_CYC cycles since the last strobe → IDLE, frame_err. No byte is emitted.

Decoder (acts on byte_valid):
- E0: set ext_pend.
- F0: set brk_pend.
- Any other byte, with brk_pend=0 (make):
  - key_code ← byte, key_ext ← ext_pend.
  - Clear both pending flags.
  - If the new code equals the current key_code, no state change and no write (typematic repeat is suppressed).
- Any other byte, with brk_pend=1 (break):
  - If byte == key_code, key_code ← 0 and key_ext ← 0; otherwise ignore the byte.
  - Clear both pending flags.
- The key stored in key_code is the last make; a newer make replaces the held key.

Write handshake:
- Any change of key_code sets wr_req=1 and loads wr_data.
- wr_req stays high until wr_ack is sampled high, then drops the next cycle.
- A further change while wr_req is high updates wr_data in place (coalescing); one ack retires the request.
- A change in the same cycle as wr_ack: the ack retires the old data, and wr_req stays high with the new data.
- wr_data and wr_addr are stable whenever wr_req=1, except in the coalescing update cycle.

## Timing

- Reset (rst=0, asynchronous):
  - FSM → IDLE; counters and pending flags clear.
  - key_code=0, key_ext=0, key_held=0, frame_err=0, wr_req=0, wr_data=0.
  - wr_addr=KEY_ADDR.
- Synchronizer latency is 2 cycles; filter latency is FILTER_LEN cycles.
- The stop-bit strobe asserts byte_valid in the same cycle. key_code updates the next cycle. wr_req rises in the same cycle as the key_code update.
- Reset asserted mid-frame discards the partial byte and any pending E0/F0. The first frame after release must start with a fresh start bit.
- FILTER_LEN × clk period must be well below half the PS/2 clock period (≥30 µs); the default qualifies at any clk ≥1 MHz.

## Test plan

- Frame 0x75 (odd parity bit 0) → key_code=0x75, key_held=1, and wr_req with addr 10 / data 0x75 is held until ack, then drops.
- Frames F0, 75 after holding 0x75 → key_code=0 and one write with data 0. F0 followed by 0x1C while 0x75 is held → no change.
- Frames E0, 75 → key_code=0x75, key_ext=1. Then E0, F0, 75 → key_code=0, key_ext=0.
- Frame 0x75 with a flipped parity bit → frame_err pulses once; key_code and wr_req are unchanged. A following good frame decodes normally.
- Stop after 4 data bits and wait TIMEOUT_CYC → frame_err, FSM back in IDLE. Then a full frame 0x29 → key_code=0x29.
- Key 0x75 make, then break without ack, wr_ack held low → a single wr_req with wr_data=0; one ack clears it. Also: rst pulsed mid-frame → all outputs return to their reset values.
